// File: rtl/prog_tick_gen.sv
// Multi-channel programmable clock-enable generator: per-channel tick strobe and
// near-50% square wave, with divisor reloads that commit glitch-free at the next wrap.
module prog_tick_gen #(
  parameter int WIDTH       = 17,
  parameter int CHANNELS    = 4,
  parameter int DEFAULT_DIV = 10000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic                sync_i,
  input  logic [CHANNELS-1:0] ld_i,
  input  logic [WIDTH-1:0]    div_in_i,
  output logic [CHANNELS-1:0] tick_o,
  output logic [CHANNELS-1:0] wave_o,
  output logic [CHANNELS-1:0] pend_o
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] act_q, act_d;
    logic [WIDTH-1:0] shd_q, shd_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             wave_q, wave_d;
    logic [WIDTH-1:0] d_eff_s;
    logic [WIDTH:0]   half_s;
    logic [WIDTH:0]   cnt_inc_s;
    logic             term_s;

    // A zero divisor behaves as one; the half period uses one extra bit so 2^WIDTH-1 cannot wrap.
    assign d_eff_s   = (act_q == {WIDTH{1'b0}}) ? WIDTH'(1) : act_q;
    assign half_s    = ({1'b0, d_eff_s} + (WIDTH+1)'(1)) >> 1;
    assign cnt_inc_s = {1'b0, cnt_q} + (WIDTH+1)'(1);
    assign term_s    = (cnt_q >= (d_eff_s - WIDTH'(1)));

    // Next-state selection: sync beats enable, and a wrap commits only the shadow held before this edge.
    always_comb begin
      cnt_d  = cnt_q;
      act_d  = act_q;
      shd_d  = shd_q;
      pend_d = pend_q;
      tick_d = 1'b0;
      wave_d = wave_q;
      if (sync_i) begin
        cnt_d  = {WIDTH{1'b0}};
        wave_d = 1'b1;
        pend_d = 1'b0;
        act_d  = ld_i[g] ? div_in_i : shd_q;
      end else begin
        if (ld_i[g]) begin
          shd_d  = div_in_i;
          pend_d = 1'b1;
        end else begin
          shd_d  = shd_q;
        end
        if (!en_i) begin
          cnt_d  = cnt_q;
        end else if (term_s) begin
          cnt_d  = {WIDTH{1'b0}};
          tick_d = 1'b1;
          wave_d = 1'b1;
          if (pend_q) begin
            act_d  = shd_q;
            pend_d = ld_i[g];
          end else begin
            act_d  = act_q;
          end
        end else begin
          cnt_d  = cnt_inc_s[WIDTH-1:0];
          wave_d = (cnt_inc_s < half_s);
        end
      end
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q  <= {WIDTH{1'b0}};
        act_q  <= DIV_RST;
        shd_q  <= DIV_RST;
        pend_q <= 1'b0;
        tick_q <= 1'b0;
        wave_q <= 1'b1;
      end else begin
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        shd_q  <= shd_d;
        pend_q <= pend_d;
        tick_q <= tick_d;
        wave_q <= wave_d;
      end
    end

    assign tick_o[g] = tick_q;
    assign wave_o[g] = wave_q;
    assign pend_o[g] = pend_q;
  end

endmodule

// File: tb/tb_prog_tick_gen.sv
// Self-checking bench for prog_tick_gen: directed scenarios plus random traffic,
// compared every cycle against a period/phase model of each channel.
module tb_prog_tick_gen;
  localparam int W   = 17;
  localparam int NCH = 4;
  localparam int DEF = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b1;
  logic           sync = 1'b0;
  logic [NCH-1:0] ld = '0;
  logic [W-1:0]   div_in = '0;
  logic [NCH-1:0] tick_o, wave_o, pend_o;

  int checks = 0;
  int errors = 0;

  prog_tick_gen #(.WIDTH(W), .CHANNELS(NCH), .DEFAULT_DIV(DEF)) dut (
    .clk(clk), .rst(rst), .en_i(en), .sync_i(sync), .ld_i(ld), .div_in_i(div_in),
    .tick_o(tick_o), .wave_o(wave_o), .pend_o(pend_o)
  );

  always #5 clk = ~clk;

  // Model: e = enabled cycles elapsed in the current period, d = period in force.
  typedef struct {
    int e; int d; int shd; bit pend; bit tick; bit wave;
  } ch_t;
  ch_t m [NCH];

  function automatic ch_t ch_reset();
    ch_t r;
    r.e = 0; r.d = DEF; r.shd = DEF; r.pend = 1'b0; r.tick = 1'b0; r.wave = 1'b1;
    return r;
  endfunction

  function automatic ch_t nxt(ch_t s, bit sy, bit ena, bit l, int din);
    ch_t n;
    int period;
    n = s;
    period = (s.d == 0) ? 1 : s.d;
    n.tick = 1'b0;
    if (sy) begin
      n.e = 0; n.wave = 1'b1; n.pend = 1'b0;
      n.d = l ? din : s.shd;
    end else begin
      if (l) begin n.shd = din; n.pend = 1'b1; end
      if (ena) begin
        if (s.e + 1 >= period) begin
          n.e = 0; n.tick = 1'b1; n.wave = 1'b1;
          if (s.pend) begin n.d = s.shd; n.pend = l; end
        end else begin
          n.e = s.e + 1;
          // high for the first ceil(period/2) cycles of every period
          n.wave = (n.e < period - period / 2);
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < NCH; i++) begin
      if (rst) m[i] <= ch_reset();
      else     m[i] <= nxt(m[i], sync, en, ld[i], int'(div_in));
    end
  end

  function automatic logic [NCH-1:0] exp_vec(int sel);
    logic [NCH-1:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) begin
      case (sel)
        0:       v[i] = m[i].tick;
        1:       v[i] = m[i].wave;
        default: v[i] = m[i].pend;
      endcase
    end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: compare against the model at the falling edge, return 2ns after the rising edge.
  task automatic cyc();
    @(negedge clk);
    chk("cyc_tick", tick_o, exp_vec(0));
    chk("cyc_wave", wave_o, exp_vec(1));
    chk("cyc_pend", pend_o, exp_vec(2));
    @(posedge clk);
    #2;
  endtask

  task automatic wait_tick(input int ch, input int lim, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!tick_o[ch] && n < lim);
    if (!tick_o[ch]) chk("tick_timeout", n, lim + 1);
  endtask

  task automatic count_wave(input int ch, input int len, output int hi);
    hi = int'(wave_o[ch]);
    repeat (len - 1) begin
      cyc();
      hi += int'(wave_o[ch]);
    end
  endtask

  initial begin
    int n, hi;
    bit seen;
    logic wv;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_tick", tick_o, 4'h0);
    chk("rst_wave", wave_o, 4'hF);
    chk("rst_pend", pend_o, 4'h0);
    rst = 1'b0;

    // default divisor 10
    wait_tick(0, 30, n); chk("first_tick", n, 10);
    chk("all_tick", tick_o, 4'hF);
    wait_tick(0, 30, n); chk("period10", n, 10);
    count_wave(0, 10, hi); chk("wave_hi10", hi, 5);

    // reload ch1 to 7 partway through a period
    sync = 1'b1; cyc(); sync = 1'b0;
    repeat (3) cyc();
    ld = 4'b0010; div_in = 17'd7; cyc(); ld = '0;
    chk("pend1_set", pend_o[1], 1'b1);
    wait_tick(1, 30, n); chk("ch1_finish10", n, 6);
    chk("pend1_clr", pend_o[1], 1'b0);
    wait_tick(1, 30, n); chk("ch1_period7", n, 7);
    count_wave(1, 7, hi); chk("wave_hi7", hi, 4);

    // ch0 D=3 and ch2 D=6 restarted in phase
    ld = 4'b0001; div_in = 17'd3; cyc();
    ld = 4'b0100; div_in = 17'd6; sync = 1'b1; cyc();
    ld = '0; sync = 1'b0;
    wait_tick(0, 30, n); chk("ch0_period3", n, 3);
    chk("ch2_quiet", tick_o[2], 1'b0);
    wait_tick(0, 30, n); chk("ch0_period3b", n, 3);
    chk("ch2_aligned", tick_o[2], 1'b1);

    // load on ch2's wrap edge stays pending one more period
    repeat (5) cyc();
    ld = 4'b0100; div_in = 17'd4; cyc(); ld = '0;
    chk("wrap_tick2", tick_o[2], 1'b1);
    chk("wrap_pend2", pend_o[2], 1'b1);
    wait_tick(2, 30, n); chk("ch2_old6", n, 6);
    chk("ch2_pend_clr", pend_o[2], 1'b0);
    wait_tick(2, 30, n); chk("ch2_new4", n, 4);

    // load on the sync edge applies immediately
    ld = 4'b0001; div_in = 17'd2; sync = 1'b1; cyc();
    ld = '0; sync = 1'b0;
    wait_tick(0, 30, n); chk("sync_ld2", n, 2);

    // en low for 5 cycles mid-period at D=8
    ld = 4'b1000; div_in = 17'd8; sync = 1'b1; cyc();
    ld = '0; sync = 1'b0;
    repeat (3) cyc();
    en = 1'b0; wv = wave_o[3]; seen = 1'b0;
    repeat (5) begin cyc(); seen |= |tick_o; end
    chk("no_tick_en0", seen, 1'b0);
    chk("wave_hold", wave_o[3], wv);
    en = 1'b1;
    wait_tick(3, 30, n); chk("en_delay", n, 5);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      en     = ($urandom_range(0, 9) != 0);
      sync   = ($urandom_range(0, 199) == 0);
      ld     = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
      div_in = 17'($urandom_range(0, 24));
      cyc();
    end
    en = 1'b1; sync = 1'b0; ld = '0;

    // divisor 0 and 1 tick every cycle, then the maximum divisor
    ld = 4'b0001; div_in = 17'd0; sync = 1'b1; cyc();
    ld = '0; sync = 1'b0;
    wait_tick(0, 30, n); chk("div0_period", n, 1);
    chk("div0_wave", wave_o[0], 1'b1);
    ld = 4'b0001; div_in = 17'd1; cyc();
    ld = 4'b0001; div_in = 17'h1FFFF; cyc();
    ld = '0; cyc();
    chk("max_commit_tick", tick_o[0], 1'b1);
    chk("max_commit_pend", pend_o[0], 1'b0);
    n = 0;
    while (wave_o[0] && n < 70000) begin n++; cyc(); end
    chk("max_wave_hi", n, 65536);

    // asynchronous reset mid-period
    ld = 4'b1110; div_in = 17'd5; cyc(); ld = '0;
    repeat (3) cyc();
    #1 rst = 1'b1;
    #1;
    chk("arst_tick", tick_o, 4'h0);
    chk("arst_wave", wave_o, 4'hF);
    chk("arst_pend", pend_o, 4'h0);
    repeat (2) cyc();
    rst = 1'b0;
    wait_tick(0, 30, n); chk("post_rst_period", n, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_tick_gen.md
Name: prog_tick_gen

Overview:
Multi-channel programmable clock-enable generator. It is the parametrised successor of the fixed-divisor tick divider. Each channel produces a one-cycle tick every D enabled clocks and a near-50% square wave. Each channel's divisor can be reloaded at runtime, and the new value takes effect glitch-free at the channel's next wrap. The block feeds display scan, debounce and UART-baud strobes from a single system clock.

Parameters:
WIDTH, 17, counter/divisor width in bits
CHANNELS, 4, number of independent divider channels
DEFAULT_DIV, 10000, divisor loaded into every channel at reset (must fit WIDTH)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  global count enable; counters advance only when high
sync  in  1  one-cycle strobe: restart all channels in phase
ld  in  CHANNELS  per-channel divisor load strobe
div_in  in  WIDTH  divisor value written by any asserted ld bit
tick  out  CHANNELS  registered one-cycle pulse per period
wave  out  CHANNELS  registered square wave, period D
pend  out  CHANNELS  high while a loaded divisor waits for its wrap

Behaviour:
- Reset is asynchronous, active-high; clock is clk. Reset values per channel:
  - cnt = 0; act_div = shd_div = DEFAULT_DIV
  - tick = 0, wave = 1, pend = 0
- Effective divisor: D = max(act_div, 1). A value of 0 is treated as 1.
- Half period: H = (D+1)>>1, computed in WIDTH+1 bits so no overflow at 2^WIDTH-1. wave is high for ceil(D/2) cycles and low for floor(D/2).
- Per-channel update on each rising edge, first matching rule wins:
  1. sync=1 (regardless of en):
     - cnt <= 0; tick <= 0; wave <= 1; pend <= 0
     - act_div <= ld[i] ? div_in : shd_div
  2. en=0:
     - cnt and wave hold; tick <= 0
     - ld still captures (see ld rule)
  3. en=1 and cnt >= D-1 (terminal; >= also covers a shrunken divisor):
     - cnt <= 0; tick <= 1; wave <= 1
     - if pend: act_div <= shd_div, pend <= 0
  4. en=1 otherwise:
     - cnt <= cnt+1; tick <= 0
     - wave <= ((cnt+1) < H)
- ld rule (when not sync): ld[i]=1 -> shd_div <= div_in and pend <= 1.
  - If the same edge is a terminal wrap, the wrap commits the OLD shd_div. The new value stays pending until the following wrap.
  - Repeated ld before a wrap: last write wins.
- Latency: with en held high, first tick occurs D cycles after reset release or after the sync edge. Subsequent ticks are exactly D cycles apart.
- D=1: tick is high every enabled cycle; wave stays 1.
- Channels are fully independent except for the shared en, sync and div_in.
- Mid-operation reset asynchronously forces the reset values, including act_div = DEFAULT_DIV; pending loads are discarded.
- No combinational path from any input to any output.

Test Plan:
- Reset, DEFAULT_DIV=10, en=1 -> tick[0] first high at cycle 10 after rst release, then every 10 cycles; wave high 5 / low 5.
- ld[1] with div_in=7 at cycle 3 while ch1 runs D=10 -> pend[1]=1; ch1 finishes the current 10-cycle period, then ticks every 7; wave 4 high / 3 low; pend clears at the wrap.
- ld coincident with a terminal edge (div_in=4 on the wrap edge of a D=6 channel) -> the next period is still 6, then 4.
- sync at an arbitrary cycle with ch0 D=3 and ch2 D=6 -> both cnt=0; tick[2] coincides with every second tick[0] from then on; ld[0] with div_in=2 on the sync edge takes effect immediately.
- en toggled low for 5 cycles mid-period with D=8 -> tick is delayed exactly 5 cycles; wave holds its level; no tick while en=0.
- div_in=0 and div_in=1 loaded, then div_in=2^17-1 -> tick every enabled cycle with wave constantly 1; max value gives period 131071, wave high 65536, no overflow. Assert rst mid-period -> all outputs return to reset values immediately.
